// File: rtl/dlx_ctrl_pkg.sv
// Shared types and constants for the DLX execution datapath: ALU opcodes,
// operand/writeback select encodings and default widths.
package dlx_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_RF_ADDR_W  = 5;
  localparam int DEF_IMM_W      = 16;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  // Operand and writeback select encodings as driven by the control FSM
  localparam logic SEL_NPC = 1'b0;
  localparam logic SEL_A   = 1'b1;
  localparam logic SEL_B   = 1'b0;
  localparam logic SEL_IMM = 1'b1;
  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_MEM = 1'b1;

endpackage

// File: rtl/dlx_datapath_if.sv
// Control word from the hardwired FSM plus the data-memory bus and status
// returned by the datapath. The control side is the master.
interface dlx_datapath_if import dlx_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RF_ADDR_W  = DEF_RF_ADDR_W,
  parameter int IMM_W      = DEF_IMM_W
);

  logic [RF_ADDR_W-1:0]  rs1;
  logic [RF_ADDR_W-1:0]  rs2;
  logic [RF_ADDR_W-1:0]  rd;
  logic [IMM_W-1:0]      imm;
  logic [DATA_WIDTH-1:0] npc;
  logic                  rf1;
  logic                  rf2;
  logic                  en1;
  logic                  s1;
  logic                  s2;
  logic                  alu1;
  logic                  alu2;
  logic                  en2;
  logic                  rm;
  logic                  wm;
  logic                  en3;
  logic                  s3;
  logic                  wf1;
  logic [DATA_WIDTH-1:0] dram_addr;
  logic [DATA_WIDTH-1:0] dram_wdata;
  logic                  dram_re;
  logic                  dram_we;
  logic [DATA_WIDTH-1:0] dram_rdata;
  logic                  alu_zero;
  logic [DATA_WIDTH-1:0] wb_data;

  modport master (
    output rs1, rs2, rd, imm, npc, rf1, rf2, en1, s1, s2, alu1, alu2, en2,
           rm, wm, en3, s3, wf1, dram_rdata,
    input  dram_addr, dram_wdata, dram_re, dram_we, alu_zero, wb_data
  );

  modport slave (
    input  rs1, rs2, rd, imm, npc, rf1, rf2, en1, s1, s2, alu1, alu2, en2,
           rm, wm, en3, s3, wf1, dram_rdata,
    output dram_addr, dram_wdata, dram_re, dram_we, alu_zero, wb_data
  );

endinterface

// File: rtl/dlx_alu.sv
// Combinational ALU: wrapping ADD/SUB and bitwise AND/OR, no flags.
module dlx_alu import dlx_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  alu_op_t               op,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic [DATA_WIDTH-1:0] result
);

  // Operation decode
  always_comb begin
    result = {DATA_WIDTH{1'b0}};
    case (op)
      ALU_ADD: result = in1 + in2;
      ALU_SUB: result = in1 - in2;
      ALU_AND: result = in1 & in2;
      ALU_OR:  result = in1 | in2;
      default: result = {DATA_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/dlx_datapath.sv
// Three-stage DLX execution datapath (register read, ALU, memory/writeback)
// stepped by the control FSM's enables; R0 is hardwired to zero.
module dlx_datapath import dlx_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RF_ADDR_W  = DEF_RF_ADDR_W,
  parameter int IMM_W      = DEF_IMM_W
) (
  input logic           clk,
  input logic           rst,
  dlx_datapath_if.slave bus
);

  localparam int NUM_REGS = 2 ** RF_ADDR_W;

  logic [DATA_WIDTH-1:0] rf_r [NUM_REGS];
  logic [DATA_WIDTH-1:0] a_r, b_r, imm_x_r, npc_1_r;
  logic [DATA_WIDTH-1:0] alu_q_r, b_2_r, wb_q_r;
  logic [RF_ADDR_W-1:0]  rd1_r, rd2_r, rd3_r;
  logic                  alu_zero_r;

  logic [DATA_WIDTH-1:0] rd_a_s, rd_b_s, imm_sext_s;
  logic [DATA_WIDTH-1:0] in1_s, in2_s, alu_res_s;
  logic                  wr_en_s;
  alu_op_t               alu_op_s;

  assign wr_en_s    = bus.wf1 && (rd3_r != {RF_ADDR_W{1'b0}});
  assign imm_sext_s = {{(DATA_WIDTH - IMM_W){bus.imm[IMM_W-1]}}, bus.imm};

  // Read ports with write-first bypass from the writeback stage
  always_comb begin
    rd_a_s = rf_r[bus.rs1];
    rd_b_s = rf_r[bus.rs2];
    if (wr_en_s && (rd3_r == bus.rs1)) begin
      rd_a_s = wb_q_r;
    end else begin
      rd_a_s = rf_r[bus.rs1];
    end
    if (wr_en_s && (rd3_r == bus.rs2)) begin
      rd_b_s = wb_q_r;
    end else begin
      rd_b_s = rf_r[bus.rs2];
    end
  end

  assign in1_s    = (bus.s1 == SEL_A)   ? a_r     : npc_1_r;
  assign in2_s    = (bus.s2 == SEL_IMM) ? imm_x_r : b_r;
  assign alu_op_s = alu_op_t'({bus.alu1, bus.alu2});

  dlx_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (alu_op_s),
    .in1    (in1_s),
    .in2    (in2_s),
    .result (alu_res_s)
  );

  // Register file write port; R0 never gets written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      rf_r[rd3_r] <= wb_q_r;
    end
  end

  // Stage 1: operand fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= {DATA_WIDTH{1'b0}};
      b_r     <= {DATA_WIDTH{1'b0}};
      imm_x_r <= {DATA_WIDTH{1'b0}};
      npc_1_r <= {DATA_WIDTH{1'b0}};
      rd1_r   <= {RF_ADDR_W{1'b0}};
    end else if (bus.en1) begin
      a_r     <= bus.rf1 ? rd_a_s : {DATA_WIDTH{1'b0}};
      b_r     <= bus.rf2 ? rd_b_s : {DATA_WIDTH{1'b0}};
      imm_x_r <= imm_sext_s;
      npc_1_r <= bus.npc;
      rd1_r   <= bus.rd;
    end
  end

  // Stage 2: execute
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q_r    <= {DATA_WIDTH{1'b0}};
      b_2_r      <= {DATA_WIDTH{1'b0}};
      rd2_r      <= {RF_ADDR_W{1'b0}};
      alu_zero_r <= 1'b1;
    end else if (bus.en2) begin
      alu_q_r    <= alu_res_s;
      b_2_r      <= b_r;
      rd2_r      <= rd1_r;
      alu_zero_r <= (alu_res_s == {DATA_WIDTH{1'b0}});
    end
  end

  // Stage 3: memory access result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q_r <= {DATA_WIDTH{1'b0}};
      rd3_r  <= {RF_ADDR_W{1'b0}};
    end else if (bus.en3) begin
      wb_q_r <= (bus.s3 == SEL_MEM) ? bus.dram_rdata : alu_q_r;
      rd3_r  <= rd2_r;
    end
  end

  // A write wins over a read if the FSM ever raises both strobes
  assign bus.dram_re    = bus.rm & ~bus.wm;
  assign bus.dram_we    = bus.wm;
  assign bus.dram_addr  = alu_q_r;
  assign bus.dram_wdata = b_2_r;
  assign bus.alu_zero   = alu_zero_r;
  assign bus.wb_data    = wb_q_r;

endmodule

// File: tb/tb_dlx_datapath.sv
// Directed self-checking bench for dlx_datapath; register contents are
// observed by routing them through the ALU onto dram_addr.
module tb_dlx_datapath;
  import dlx_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  dlx_datapath_if bus ();

  dlx_datapath dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    bus.en1 = 1'b0; bus.en2 = 1'b0; bus.en3 = 1'b0; bus.wf1 = 1'b0;
    bus.rm  = 1'b0; bus.wm  = 1'b0; rst = 1'b0;
  endtask

  task automatic s1_issue(input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                          input logic [4:0] rd_v, input logic [15:0] imm_v,
                          input logic [31:0] npc_v, input logic rf1_v, input logic rf2_v);
    bus.rs1 = rs1_v; bus.rs2 = rs2_v; bus.rd = rd_v; bus.imm = imm_v;
    bus.npc = npc_v; bus.rf1 = rf1_v; bus.rf2 = rf2_v; bus.en1 = 1'b1;
    tick();
  endtask

  task automatic s2_exec(input logic [1:0] op_v, input logic s1_v, input logic s2_v);
    {bus.alu1, bus.alu2} = op_v; bus.s1 = s1_v; bus.s2 = s2_v; bus.en2 = 1'b1;
    tick();
  endtask

  task automatic s3_mem(input logic s3_v);
    bus.s3 = s3_v; bus.en3 = 1'b1;
    tick();
  endtask

  task automatic wb();
    bus.wf1 = 1'b1;
    tick();
  endtask

  // Loads a register by passing NPC through the ALU and writing it back
  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    s1_issue(5'd0, 5'd0, r, 16'h0000, v, 1'b0, 1'b0);
    s2_exec(ALU_ADD, SEL_NPC, SEL_IMM);
    s3_mem(SEL_ALU);
    wb();
  endtask

  // Leaves rf[r] + 0 on dram_addr
  task automatic read_reg(input logic [4:0] r);
    s1_issue(r, 5'd0, 5'd0, 16'h0000, 32'h0, 1'b1, 1'b0);
    s2_exec(ALU_ADD, SEL_A, SEL_IMM);
  endtask

  task automatic test_reset();
    write_reg(5'd3, 32'd5);
    s1_issue(5'd0, 5'd0, 5'd6, 16'h0000, 32'd9, 1'b0, 1'b0);
    s2_exec(ALU_ADD, SEL_NPC, SEL_IMM);
    s3_mem(SEL_ALU);
    rst = 1'b1; bus.wf1 = 1'b1; bus.en1 = 1'b1; bus.en2 = 1'b1; bus.en3 = 1'b1;
    bus.rm = 1'b1;
    #1;
    checks++;
    if (bus.dram_re !== 1'b1) begin
      failures++; $display("FAIL reset_re_comb got=%b exp=1", bus.dram_re);
    end
    tick();
    checks++;
    if (bus.dram_addr !== 32'h0) begin
      failures++; $display("FAIL reset_alu_q got=%h exp=0", bus.dram_addr);
    end
    checks++;
    if (bus.wb_data !== 32'h0) begin
      failures++; $display("FAIL reset_wb_q got=%h exp=0", bus.wb_data);
    end
    checks++;
    if (bus.alu_zero !== 1'b1) begin
      failures++; $display("FAIL reset_zero got=%b exp=1", bus.alu_zero);
    end
    s1_issue(5'd3, 5'd0, 5'd0, 16'h0000, 32'h0, 1'b1, 1'b0);
    s2_exec(ALU_ADD, SEL_A, SEL_B);
    checks++;
    if (bus.dram_addr !== 32'h0 || bus.alu_zero !== 1'b1) begin
      failures++; $display("FAIL reset_rf3 got=%h/%b exp=0/1", bus.dram_addr, bus.alu_zero);
    end
    read_reg(5'd6);
    checks++;
    if (bus.dram_addr !== 32'h0) begin
      failures++; $display("FAIL reset_discard got=%h exp=0", bus.dram_addr);
    end
  endtask

  task automatic test_add_wb();
    write_reg(5'd1, 32'd7);
    write_reg(5'd2, 32'd9);
    s1_issue(5'd1, 5'd2, 5'd4, 16'h0000, 32'h0, 1'b1, 1'b1);
    s2_exec(ALU_ADD, SEL_A, SEL_B);
    checks++;
    if (bus.dram_addr !== 32'd16 || bus.alu_zero !== 1'b0) begin
      failures++; $display("FAIL add_alu got=%h/%b exp=10/0", bus.dram_addr, bus.alu_zero);
    end
    s3_mem(SEL_ALU);
    checks++;
    if (bus.wb_data !== 32'd16) begin
      failures++; $display("FAIL add_wb_data got=%h exp=10", bus.wb_data);
    end
    read_reg(5'd4);
    checks++;
    if (bus.dram_addr !== 32'h0) begin
      failures++; $display("FAIL add_early_write got=%h exp=0", bus.dram_addr);
    end
    wb();
    read_reg(5'd4);
    checks++;
    if (bus.dram_addr !== 32'd16) begin
      failures++; $display("FAIL add_rf4 got=%h exp=10", bus.dram_addr);
    end
  endtask

  task automatic test_imm_sub();
    write_reg(5'd1, 32'd3);
    s1_issue(5'd1, 5'd0, 5'd0, 16'hFFFC, 32'h0, 1'b1, 1'b0);
    s2_exec(ALU_SUB, SEL_A, SEL_IMM);
    checks++;
    if (bus.dram_addr !== 32'd7) begin
      failures++; $display("FAIL sub_imm got=%h exp=7", bus.dram_addr);
    end
    write_reg(5'd1, 32'd0);
    s1_issue(5'd1, 5'd0, 5'd0, 16'h0000, 32'h0, 1'b1, 1'b0);
    s2_exec(ALU_SUB, SEL_A, SEL_IMM);
    checks++;
    if (bus.dram_addr !== 32'h0 || bus.alu_zero !== 1'b1) begin
      failures++; $display("FAIL sub_zero got=%h/%b exp=0/1", bus.dram_addr, bus.alu_zero);
    end
  endtask

  task automatic test_wrap();
    write_reg(5'd7, 32'hFFFF_FFFF);
    s1_issue(5'd7, 5'd0, 5'd0, 16'h0001, 32'h0, 1'b1, 1'b0);
    s2_exec(ALU_ADD, SEL_A, SEL_IMM);
    checks++;
    if (bus.dram_addr !== 32'h0 || bus.alu_zero !== 1'b1) begin
      failures++; $display("FAIL wrap_add got=%h/%b exp=0/1", bus.dram_addr, bus.alu_zero);
    end
    checks++;
    if (bus.wb_data !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL wrap_side_effect got=%h exp=ffffffff", bus.wb_data);
    end
    read_reg(5'd7);
    checks++;
    if (bus.dram_addr !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL wrap_rf7 got=%h exp=ffffffff", bus.dram_addr);
    end
  endtask

  task automatic test_logic();
    write_reg(5'd8, 32'hF0F0_1234);
    write_reg(5'd9, 32'h0FF0_FF00);
    s1_issue(5'd8, 5'd9, 5'd0, 16'h0000, 32'h0, 1'b1, 1'b1);
    s2_exec(ALU_AND, SEL_A, SEL_B);
    checks++;
    if (bus.dram_addr !== 32'h00F0_1200) begin
      failures++; $display("FAIL and_op got=%h exp=00f01200", bus.dram_addr);
    end
    s2_exec(ALU_OR, SEL_A, SEL_B);
    checks++;
    if (bus.dram_addr !== 32'hFFF0_FF34) begin
      failures++; $display("FAIL or_op got=%h exp=fff0ff34", bus.dram_addr);
    end
  endtask

  task automatic test_load_store();
    write_reg(5'd10, 32'd100);
    write_reg(5'd11, 32'hCAFE_0001);
    s1_issue(5'd10, 5'd11, 5'd0, 16'h0008, 32'h0, 1'b1, 1'b1);
    s2_exec(ALU_ADD, SEL_A, SEL_IMM);
    bus.wm = 1'b1; bus.rm = 1'b0;
    #1;
    checks++;
    if (bus.dram_we !== 1'b1 || bus.dram_re !== 1'b0 || bus.dram_addr !== 32'd108
        || bus.dram_wdata !== 32'hCAFE_0001) begin
      failures++; $display("FAIL store got=%b%b %h %h exp=10 0000006c cafe0001",
                           bus.dram_we, bus.dram_re, bus.dram_addr, bus.dram_wdata);
    end
    bus.rm = 1'b1;
    #1;
    checks++;
    if (bus.dram_we !== 1'b1 || bus.dram_re !== 1'b0) begin
      failures++; $display("FAIL rm_wm_both got=we%b re%b exp=we1 re0", bus.dram_we, bus.dram_re);
    end
    bus.rm = 1'b0;
    s3_mem(SEL_ALU);
    s1_issue(5'd10, 5'd0, 5'd12, 16'h0004, 32'h0, 1'b1, 1'b0);
    s2_exec(ALU_ADD, SEL_A, SEL_IMM);
    bus.rm = 1'b1; bus.dram_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.dram_re !== 1'b1 || bus.dram_we !== 1'b0 || bus.dram_addr !== 32'd104) begin
      failures++; $display("FAIL load_bus got=re%b we%b %h exp=re1 we0 00000068",
                           bus.dram_re, bus.dram_we, bus.dram_addr);
    end
    s3_mem(SEL_MEM);
    bus.dram_rdata = 32'h0;
    wb();
    read_reg(5'd12);
    checks++;
    if (bus.dram_addr !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL load_rf12 got=%h exp=deadbeef", bus.dram_addr);
    end
  endtask

  task automatic test_r0_bypass();
    // Write to R0 with a same-edge read of R0: both dropped/suppressed
    s1_issue(5'd0, 5'd0, 5'd0, 16'h0000, 32'd55, 1'b0, 1'b0);
    s2_exec(ALU_ADD, SEL_NPC, SEL_IMM);
    s3_mem(SEL_ALU);
    bus.wf1 = 1'b1;
    s1_issue(5'd0, 5'd0, 5'd0, 16'h0000, 32'h0, 1'b1, 1'b0);
    s2_exec(ALU_ADD, SEL_A, SEL_IMM);
    checks++;
    if (bus.dram_addr !== 32'h0) begin
      failures++; $display("FAIL r0_bypass got=%h exp=0", bus.dram_addr);
    end
    read_reg(5'd0);
    checks++;
    if (bus.dram_addr !== 32'h0) begin
      failures++; $display("FAIL r0_write got=%h exp=0", bus.dram_addr);
    end
    // rf[5]=42 written in the same edge that stage 1 reads it
    s1_issue(5'd0, 5'd0, 5'd5, 16'h0000, 32'd42, 1'b0, 1'b0);
    s2_exec(ALU_ADD, SEL_NPC, SEL_IMM);
    s3_mem(SEL_ALU);
    bus.wf1 = 1'b1;
    s1_issue(5'd5, 5'd5, 5'd0, 16'h0000, 32'h0, 1'b1, 1'b1);
    s2_exec(ALU_ADD, SEL_A, SEL_B);
    checks++;
    if (bus.dram_addr !== 32'd84) begin
      failures++; $display("FAIL bypass_ab got=%h exp=54", bus.dram_addr);
    end
    read_reg(5'd5);
    checks++;
    if (bus.dram_addr !== 32'd42) begin
      failures++; $display("FAIL bypass_rf5 got=%h exp=2a", bus.dram_addr);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.rd = 5'd0; bus.imm = 16'h0;
    bus.npc = 32'h0; bus.rf1 = 1'b0; bus.rf2 = 1'b0; bus.en1 = 1'b0;
    bus.s1 = 1'b0; bus.s2 = 1'b0; bus.alu1 = 1'b0; bus.alu2 = 1'b0;
    bus.en2 = 1'b0; bus.rm = 1'b0; bus.wm = 1'b0; bus.en3 = 1'b0;
    bus.s3 = 1'b0; bus.wf1 = 1'b0; bus.dram_rdata = 32'h0;
    rst = 1'b1;
    @(posedge clk);
    rst = 1'b1;
    tick();
    test_reset();
    test_add_wb();
    test_imm_sub();
    test_wrap();
    test_logic();
    test_load_store();
    test_r0_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
